ppl_exit: RTL

Tail stage of the ray-march pipeline, and the counterpart of the pipeline entry stage. Each cycle it takes the ray leaving the last march stage and decides whether to retire it or recirculate it. A retired ray (hit, step limit, or out of map) is shaded and queued to the framebuffer. A recirculated ray is fed back to the entry stage on the `end_pos_*` / `ray_slope_out_*` / `block_cnt_out` / `pixel_addr_out` path. The block also counts retired pixels and raises `scanner_stop` when the frame is complete.

---
 rtl/ppl_exit.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ppl_exit.sv
// Tail of the ray-march pipeline: retires finished rays to a framebuffer write queue, recirculates the rest.
// Latency: every output is registered; the decision for the cycle-N ray appears at N+1, and retire-to-fb_we is 1 cycle when the queue is empty.
// Backpressure: fb_we/fb_ready handshake drains the queue; a retiring ray that meets a full queue is recirculated unchanged.
//
// Ports:
//   clk, rst                  clock and asynchronous active-low reset
//   in_valid, pos_*, ray_slope_*, block_cnt, pixel_addr, hit, hit_face, hit_color
//                             ray leaving the last march stage
//   next_en, end_pos_*, ray_slope_out_*, block_cnt_out, pixel_addr_out
//                             slot-free flag and recirculation path back to the entry stage
//   frame_start, scanner_stop, frame_done
//                             frame pixel-count control
//   fb_we, fb_addr, fb_data, fb_ready
//                             framebuffer write port (valid/ready)
module ppl_exit #(
  parameter int          H_DISP     = 1280,
  parameter int          V_DISP     = 720,
  parameter int          MAX_STEPS  = 20,
  parameter int          MAP_SIZE   = 14,
  parameter logic [15:0] SKY_COLOR  = 16'h867D,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] pos_x,
  input  logic [15:0] pos_y,
  input  logic [15:0] pos_z,
  input  logic [15:0] ray_slope_x,
  input  logic [15:0] ray_slope_y,
  input  logic [15:0] ray_slope_z,
  input  logic [4:0]  block_cnt,
  input  logic [19:0] pixel_addr,
  input  logic        hit,
  input  logic [1:0]  hit_face,
  input  logic [15:0] hit_color,
  output logic        next_en,
  output logic [15:0] end_pos_x,
  output logic [15:0] end_pos_y,
  output logic [15:0] end_pos_z,
  output logic [15:0] ray_slope_out_x,
  output logic [15:0] ray_slope_out_y,
  output logic [15:0] ray_slope_out_z,
  output logic [4:0]  block_cnt_out,
  output logic [19:0] pixel_addr_out,
  output logic        scanner_stop,
  input  logic        frame_start,
  output logic        frame_done,
  output logic        fb_we,
  output logic [19:0] fb_addr,
  output logic [15:0] fb_data,
  input  logic        fb_ready
);

  localparam int          AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW        = AW + 1;
  localparam logic [19:0] PIX_TOTAL = 20'(H_DISP * V_DISP);
  localparam logic [4:0]  LAST_STEP = 5'(MAX_STEPS - 1);
  localparam logic [3:0]  MAP_LIM   = 4'(MAP_SIZE);

  typedef struct packed {
    logic [19:0] addr;
    logic [15:0] data;
  } fb_ent_t;

  // recirculation registers
  logic        next_en_q, next_en_d;
  logic [15:0] end_pos_x_q, end_pos_x_d, end_pos_y_q, end_pos_y_d, end_pos_z_q, end_pos_z_d;
  logic [15:0] slope_x_q, slope_x_d, slope_y_q, slope_y_d, slope_z_q, slope_z_d;
  logic [4:0]  block_cnt_out_q, block_cnt_out_d;
  logic [19:0] pixel_addr_out_q, pixel_addr_out_d;

  // write queue
  fb_ent_t     mem_q [FIFO_DEPTH];
  fb_ent_t     mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // frame control
  logic [19:0] pix_cnt_q, pix_cnt_d;
  logic        scanner_stop_q, scanner_stop_d;
  logic        frame_done_q, frame_done_d;
  logic        done_q, done_d;

  logic        oob, retire, full, empty, push, pop;
  logic [4:0]  r_ch, b_ch, r_sh, b_sh;
  logic [5:0]  g_ch, g_sh;
  logic [15:0] colour;
  fb_ent_t     head;

  assign oob    = (pos_x[15:12] >= MAP_LIM) | (pos_y[15:12] >= MAP_LIM) | (pos_z[15:12] >= MAP_LIM);
  assign retire = in_valid & (hit | (block_cnt >= LAST_STEP) | oob);
  assign full   = (count_q == CW'(FIFO_DEPTH));
  assign empty  = (count_q == '0);
  // Once the frame is complete the entry stage feeds dummies; they retire silently.
  assign push   = retire & ~full & ~scanner_stop_q;
  assign pop    = ~empty & fb_ready;
  assign head   = mem_q[rd_ptr_q];

  // Per-channel face shading of the RGB565 texel.
  always_comb begin
    r_ch = hit_color[15:11];
    g_ch = hit_color[10:5];
    b_ch = hit_color[4:0];
    r_sh = r_ch;
    g_sh = g_ch;
    b_sh = b_ch;
    case (hit_face)
      2'd1: begin
        r_sh = r_ch - (r_ch >> 2);
        g_sh = g_ch - (g_ch >> 2);
        b_sh = b_ch - (b_ch >> 2);
      end
      2'd2: begin
        r_sh = r_ch >> 1;
        g_sh = g_ch >> 1;
        b_sh = b_ch >> 1;
      end
      2'd3: begin
        r_sh = r_ch - (r_ch >> 3);
        g_sh = g_ch - (g_ch >> 3);
        b_sh = b_ch - (b_ch >> 3);
      end
      default: ;
    endcase
    colour = hit ? {r_sh, g_sh, b_sh} : SKY_COLOR;
  end

  // Recirculation decision. A retire blocked by a full queue goes around again
  // without consuming a step, so the step limit cannot be overshot while stalled.
  always_comb begin
    next_en_d        = 1'b1;
    end_pos_x_d      = '0;
    end_pos_y_d      = '0;
    end_pos_z_d      = '0;
    slope_x_d        = '0;
    slope_y_d        = '0;
    slope_z_d        = '0;
    block_cnt_out_d  = '0;
    pixel_addr_out_d = '0;
    if (in_valid && (!retire || full)) begin
      next_en_d        = 1'b0;
      end_pos_x_d      = pos_x;
      end_pos_y_d      = pos_y;
      end_pos_z_d      = pos_z;
      slope_x_d        = ray_slope_x;
      slope_y_d        = ray_slope_y;
      slope_z_d        = ray_slope_z;
      pixel_addr_out_d = pixel_addr;
      if (retire)
        block_cnt_out_d = block_cnt;
      else
        block_cnt_out_d = (block_cnt == 5'd31) ? 5'd31 : block_cnt + 5'd1;
    end
  end

  // Write queue bookkeeping; depth is a power of two so pointers wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{addr: pixel_addr, data: colour};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop)
      rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Frame counting; frame_start wins over a same-cycle count.
  always_comb begin
    pix_cnt_d      = pix_cnt_q;
    scanner_stop_d = scanner_stop_q;
    done_d         = done_q;
    frame_done_d   = 1'b0;
    if (frame_start) begin
      pix_cnt_d      = '0;
      scanner_stop_d = 1'b0;
      done_d         = 1'b0;
    end else begin
      if (push) begin
        pix_cnt_d = pix_cnt_q + 20'd1;
        if (pix_cnt_q == PIX_TOTAL - 20'd1)
          scanner_stop_d = 1'b1;
      end
      // done_q makes this a single pulse per frame.
      if (scanner_stop_q && empty && !done_q) begin
        frame_done_d = 1'b1;
        done_d       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      next_en_q        <= 1'b1;
      end_pos_x_q      <= '0;
      end_pos_y_q      <= '0;
      end_pos_z_q      <= '0;
      slope_x_q        <= '0;
      slope_y_q        <= '0;
      slope_z_q        <= '0;
      block_cnt_out_q  <= '0;
      pixel_addr_out_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      pix_cnt_q        <= '0;
      scanner_stop_q   <= 1'b0;
      frame_done_q     <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      next_en_q        <= next_en_d;
      end_pos_x_q      <= end_pos_x_d;
      end_pos_y_q      <= end_pos_y_d;
      end_pos_z_q      <= end_pos_z_d;
      slope_x_q        <= slope_x_d;
      slope_y_q        <= slope_y_d;
      slope_z_q        <= slope_z_d;
      block_cnt_out_q  <= block_cnt_out_d;
      pixel_addr_out_q <= pixel_addr_out_d;
      mem_q            <= mem_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      pix_cnt_q        <= pix_cnt_d;
      scanner_stop_q   <= scanner_stop_d;
      frame_done_q     <= frame_done_d;
      done_q           <= done_d;
    end
  end

  assign next_en         = next_en_q;
  assign end_pos_x       = end_pos_x_q;
  assign end_pos_y       = end_pos_y_q;
  assign end_pos_z       = end_pos_z_q;
  assign ray_slope_out_x = slope_x_q;
  assign ray_slope_out_y = slope_y_q;
  assign ray_slope_out_z = slope_z_q;
  assign block_cnt_out   = block_cnt_out_q;
  assign pixel_addr_out  = pixel_addr_out_q;
  assign scanner_stop    = scanner_stop_q;
  assign frame_done      = frame_done_q;
  assign fb_we           = ~empty;
  // Stale entries stay in storage after popping; hide them while the queue is empty.
  assign fb_addr         = empty ? 20'd0 : head.addr;
  assign fb_data         = empty ? 16'd0 : head.data;

endmodule
